// File: rtl/mux2_rr_arbiter.sv
// Round-robin front end for the 2:1 data mux: picks one of two valid/ready
// sources, drives the mux select and registers the chosen word for the consumer.
module mux2_rr_arbiter #(
    parameter int data_size = 4,
    parameter int cnt_size  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dia_valid,
    input  logic [data_size-1:0] dia,
    output logic                 dia_ready,
    input  logic                 dib_valid,
    input  logic [data_size-1:0] dib,
    output logic                 dib_ready,
    output logic                 sel,
    output logic                 dout_valid,
    output logic [data_size-1:0] dout,
    input  logic                 dout_ready,
    output logic [cnt_size-1:0]  grant_cnt_a,
    output logic [cnt_size-1:0]  grant_cnt_b
);

    logic last_b;
    logic accept;
    logic grant_a;
    logic grant_b;
    logic xfer;

    // A tie goes to whichever source did not win last; with no request the
    // select parks on the previous winner so the mux output does not glitch.
    always_comb begin
        accept    = !dout_valid || dout_ready;
        grant_a   = dia_valid && (!dib_valid || last_b);
        grant_b   = dib_valid && (!dia_valid || !last_b);
        sel       = grant_b ? 1'b1 : (grant_a ? 1'b0 : last_b);
        dia_ready = !rst && accept && grant_a;
        dib_ready = !rst && accept && grant_b;
        xfer      = dia_ready || dib_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid  <= 1'b0;
            dout        <= '0;
            last_b      <= 1'b1;
            grant_cnt_a <= '0;
            grant_cnt_b <= '0;
        end else if (xfer) begin
            dout       <= sel ? dib : dia;
            dout_valid <= 1'b1;
            last_b     <= sel;
            if (grant_a && grant_cnt_a != '1)
                grant_cnt_a <= grant_cnt_a + 1'b1;
            if (grant_b && grant_cnt_b != '1)
                grant_cnt_b <= grant_cnt_b + 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: a vector table for arbitration, stall and
// drain/load behaviour, plus hand sequences for counter saturation and mid-stream reset.
module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       dia_valid, dib_valid, dout_ready;
    logic [3:0] dia, dib;
    logic       dia_ready, dib_ready, sel, dout_valid;
    logic [3:0] dout;
    logic [7:0] grant_cnt_a, grant_cnt_b;

    logic       s_dia_ready, s_dib_ready, s_sel, s_dout_valid;
    logic [3:0] s_dout;
    logic [1:0] s_cnt_a, s_cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.data_size(4), .cnt_size(8)) dut (
        .clk(clk), .rst(rst),
        .dia_valid(dia_valid), .dia(dia), .dia_ready(dia_ready),
        .dib_valid(dib_valid), .dib(dib), .dib_ready(dib_ready),
        .sel(sel), .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
        .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    mux2_rr_arbiter #(.data_size(4), .cnt_size(2)) dut_sat (
        .clk(clk), .rst(rst),
        .dia_valid(dia_valid), .dia(dia), .dia_ready(s_dia_ready),
        .dib_valid(dib_valid), .dib(dib), .dib_ready(s_dib_ready),
        .sel(s_sel), .dout_valid(s_dout_valid), .dout(s_dout), .dout_ready(dout_ready),
        .grant_cnt_a(s_cnt_a), .grant_cnt_b(s_cnt_b)
    );

    typedef struct {
        logic       pre_reset;
        logic       av;
        logic [3:0] a;
        logic       bv;
        logic [3:0] b;
        logic       dr;
        logic       exp_sel;
        logic       exp_ra;
        logic       exp_rb;
        logic       exp_dv;
        logic [3:0] exp_dout;
        logic [7:0] exp_ca;
        logic [7:0] exp_cb;
    } vec_t;

    vec_t vecs [16];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic av, input logic [3:0] a, input logic bv,
                                  input logic [3:0] b, input logic dr);
        dia_valid  = av;
        dia        = a;
        dib_valid  = bv;
        dib        = b;
        dout_ready = dr;
    endtask

    // Entered and left at posedge+1; leaves the DUT one cycle out of reset.
    task automatic do_reset();
        rst = 1'b1;
        apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        @(posedge clk);
        #1;

        //        rst  av  a     bv  b     dr   sel  ra   rb   dv   dout  ca  cb
        vecs[0]  = '{1'b1, 1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 8'd1, 8'd0};
        vecs[1]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 8'd1, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 8'd1, 8'd1};
        vecs[3]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 8'd2, 8'd1};
        vecs[4]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 8'd2, 8'd2};
        vecs[5]  = '{1'b0, 1'b1, 4'h6, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 8'd2, 8'd2};
        vecs[6]  = '{1'b0, 1'b1, 4'h6, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 8'd2, 8'd2};
        vecs[7]  = '{1'b0, 1'b1, 4'h6, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 8'd2, 8'd2};
        vecs[8]  = '{1'b0, 1'b1, 4'h6, 1'b1, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 8'd3, 8'd2};
        vecs[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA, 8'd3, 8'd3};
        vecs[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 8'd3, 8'd3};
        vecs[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 8'd3, 8'd3};
        vecs[12] = '{1'b0, 1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 8'd4, 8'd3};
        vecs[13] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h7, 8'd4, 8'd3};
        vecs[14] = '{1'b0, 1'b1, 4'h9, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 8'd4, 8'd3};
        vecs[15] = '{1'b0, 1'b1, 4'h1, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hC, 8'd4, 8'd4};

        // Reset state: idle select parks on B, readies low while rst is high.
        rst = 1'b1;
        apply_stimulus(1'b1, 4'h1, 1'b1, 4'h2, 1'b1);
        #3;
        check_output("reset dia_ready", 32'(dia_ready), 32'd0);
        check_output("reset dib_ready", 32'(dib_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        #3;
        check_output("reset dout_valid", 32'(dout_valid), 32'd0);
        check_output("reset dout", 32'(dout), 32'd0);
        check_output("reset cnt_a", 32'(grant_cnt_a), 32'd0);
        check_output("reset cnt_b", 32'(grant_cnt_b), 32'd0);
        check_output("reset idle sel", 32'(sel), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].pre_reset) do_reset();
            apply_stimulus(vecs[i].av, vecs[i].a, vecs[i].bv, vecs[i].b, vecs[i].dr);
            #3;
            check_output($sformatf("row%0d sel", i), 32'(sel), 32'(vecs[i].exp_sel));
            check_output($sformatf("row%0d dia_ready", i), 32'(dia_ready), 32'(vecs[i].exp_ra));
            check_output($sformatf("row%0d dib_ready", i), 32'(dib_ready), 32'(vecs[i].exp_rb));
            @(posedge clk);
            #1;
            check_output($sformatf("row%0d dout_valid", i), 32'(dout_valid), 32'(vecs[i].exp_dv));
            check_output($sformatf("row%0d dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            check_output($sformatf("row%0d cnt_a", i), 32'(grant_cnt_a), 32'(vecs[i].exp_ca));
            check_output($sformatf("row%0d cnt_b", i), 32'(grant_cnt_b), 32'(vecs[i].exp_cb));
        end

        // Saturation: the 2-bit counter stops at 3 while the 8-bit one keeps counting.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 4'(i), 1'b0, 4'h0, 1'b1);
            @(posedge clk);
            #1;
            check_output($sformatf("sat step%0d cnt_a", i), 32'(s_cnt_a), (i < 3) ? 32'(i + 1) : 32'd3);
            check_output($sformatf("wide step%0d cnt_a", i), 32'(grant_cnt_a), 32'(i + 1));
        end
        check_output("sat cnt_b", 32'(s_cnt_b), 32'd0);

        // Mid-stream reset discards the held word and restores A-first tie breaking.
        do_reset();
        apply_stimulus(1'b1, 4'h5, 1'b0, 4'h0, 1'b0);
        @(posedge clk);
        #1;
        check_output("pre-reset dout", 32'(dout), 32'h5);
        check_output("pre-reset dout_valid", 32'(dout_valid), 32'd1);
        rst = 1'b1;
        apply_stimulus(1'b1, 4'h4, 1'b1, 4'hB, 1'b1);
        #3;
        check_output("mid-reset dia_ready", 32'(dia_ready), 32'd0);
        check_output("mid-reset dib_ready", 32'(dib_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("post-reset dout_valid", 32'(dout_valid), 32'd0);
        check_output("post-reset dout", 32'(dout), 32'd0);
        check_output("post-reset cnt_a", 32'(grant_cnt_a), 32'd0);
        check_output("post-reset cnt_b", 32'(grant_cnt_b), 32'd0);
        #3;
        check_output("post-reset tie sel", 32'(sel), 32'd0);
        check_output("post-reset tie dia_ready", 32'(dia_ready), 32'd1);
        @(posedge clk);
        #1;
        check_output("post-reset tie dout", 32'(dout), 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
